load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: formats byte/half/word accesses onto a word-wide
// data memory port, with a four-state request/response handshake.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        req_legal;
  logic        req_misaligned;
  logic        req_bad;
  logic [31:0] load_lane;
  logic [31:0] load_fmt;
  logic [3:0]  store_strb;
  logic [31:0] store_data;

  assign accept  = req_valid && req_ready;
  assign req_bad = !req_legal || req_misaligned;

  // NOTE: every combinational output gets a default first, so no path through
  // the case statements can leave a signal unassigned and infer a latch.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: req_legal = 1'b1;
      3'b100, 3'b101:         req_legal = !req_write;
      default:                req_legal = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  // Load data arrives on the lane selected by the low address bits.
  assign load_lane = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_fmt = load_lane;
    case (funct3_q)
      3'b000:  load_fmt = {{24{load_lane[7]}}, load_lane[7:0]};
      3'b001:  load_fmt = {{16{load_lane[15]}}, load_lane[15:0]};
      3'b100:  load_fmt = {24'd0, load_lane[7:0]};
      3'b101:  load_fmt = {16'd0, load_lane[15:0]};
      default: load_fmt = load_lane;
    endcase
  end

  always_comb begin
    store_strb = 4'b1111;
    store_data = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        store_strb = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_strb = 4'b0011 << addr_q[1:0];
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_strb = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = req_bad ? RESP : ISSUE;
      ISSUE: if (mem_req_ready) state_next = write_q ? RESP : WAIT;
      WAIT:  if (mem_rvalid) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the captured request is cleared on reset too, so an abandoned
  // operation leaves nothing behind that a later cycle could expose.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      if (accept) begin
        write_q  <= req_write;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        rdata_q  <= 32'd0;
        error_q  <= req_bad;
      end
      if (state == WAIT && mem_rvalid) rdata_q <= load_fmt;
    end
  end

  always_comb begin
    req_ready     = (state == IDLE) && !reset;
    mem_req_valid = 1'b0;
    mem_addr      = 32'd0;
    mem_we        = 1'b0;
    mem_wstrb     = 4'd0;
    mem_wdata     = 32'd0;
    resp_valid    = 1'b0;
    resp_rdata    = 32'd0;
    resp_error    = 1'b0;
    case (state)
      ISSUE: begin
        mem_req_valid = 1'b1;
        mem_addr      = {addr_q[31:2], 2'b00};
        mem_we        = write_q;
        if (write_q) begin
          mem_wstrb = store_strb;
          mem_wdata = store_data;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_error = error_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes, 0 for an unknown funct3.
  function automatic int access_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_error(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int n = access_bytes(f3);
    if (n == 0) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    int n   = access_bytes(f3);
    int off = int'(addr[1:0]);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = access_bytes(f3);
    logic [31:0] r = 32'd0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int     n = access_bytes(f3);
    longint m = longint'(1) << (8 * n);
    longint v = {32'd0, word};
    v = (v >> (8 * int'(addr[1:0]))) % m;
    if (f3 < 3'd4 && n < 4 && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_error"}, 32'(resp_error), 32'd0);
  endtask

  // One complete transaction from IDLE back to IDLE.
  task automatic do_txn(input string tag, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int rdy_dly, input int rv_dly);
    bit err = model_error(wr, f3, addr);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0; req_write = ~wr; req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    if (err) begin
      check({tag, "_err_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_err_flag"}, 32'(resp_error), 32'd1);
      check({tag, "_err_rdata"}, resp_rdata, 32'd0);
      check({tag, "_err_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    end else begin
      for (int c = 0; c <= rdy_dly; c++) begin
        mem_req_ready = (c == rdy_dly);
        check({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd1);
        check({tag, "_mem_addr"}, mem_addr, addr - (addr % 4));
        check({tag, "_mem_we"}, 32'(mem_we), 32'(wr));
        check({tag, "_mem_wstrb"}, 32'(mem_wstrb), wr ? 32'(model_strb(f3, addr)) : 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, wr ? model_wdata(f3, wd) : 32'd0);
        check({tag, "_issue_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_issue_req_ready"}, 32'(req_ready), 32'd0);
        tick();
      end
      mem_req_ready = 1'b0;
      if (!wr) begin
        for (int c = 0; c <= rv_dly; c++) begin
          mem_rvalid = (c == rv_dly);
          mem_rdata  = (c == rv_dly) ? rd : $urandom;
          check({tag, "_wait_resp_valid"}, 32'(resp_valid), 32'd0);
          check({tag, "_wait_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
          tick();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_resp_error"}, 32'(resp_error), 32'd0);
      check({tag, "_resp_rdata"}, resp_rdata, wr ? 32'd0 : model_load(f3, addr, rd));
      check({tag, "_resp_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    end
    tick();
    check({tag, "_after_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_after_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_after_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in its cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_req_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // Reset state
    tick(); tick();
    check("reset_req_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("reset_req_ready_high", 32'(req_ready), 32'd1);
    check_quiet("reset");

    // Directed loads, stores and error cases
    do_txn("lb_0x11", 1'b0, 3'd0, 32'h0000_0011, 32'd0, 32'h1234_80FF, 0, 1);
    do_txn("lhu_0x22", 1'b0, 3'd5, 32'h0000_0022, 32'd0, 32'hBEEF_0000, 0, 0);
    do_txn("lh_0x22", 1'b0, 3'd1, 32'h0000_0022, 32'd0, 32'hBEEF_0000, 1, 2);
    do_txn("sb_0x7", 1'b1, 3'd0, 32'h0000_0007, 32'h0000_00AB, 32'd0, 3, 0);
    do_txn("sh_0x2", 1'b1, 3'd1, 32'h0000_0002, 32'h1234_5678, 32'd0, 0, 0);
    do_txn("lw_mis_0x6", 1'b0, 3'd2, 32'h0000_0006, 32'd0, 32'd0, 0, 0);
    do_txn("store_f3_100", 1'b1, 3'd4, 32'h0000_0000, 32'h5555_5555, 32'd0, 0, 0);
    do_txn("lh_mis_0x3", 1'b0, 3'd1, 32'h0000_0003, 32'd0, 32'd0, 0, 0);
    do_txn("load_f3_111", 1'b0, 3'd7, 32'h0000_0000, 32'd0, 32'd0, 0, 0);

    // Back-to-back SW then LW with req_valid held high
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h8; req_wdata = 32'hCAFE_F00D;
    check("b2b_sw_ready", 32'(req_ready), 32'd1);
    tick();
    req_write = 1'b0;
    check("b2b_sw_issue_we", 32'(mem_we), 32'd1);
    check("b2b_sw_issue_wdata", mem_wdata, 32'hCAFE_F00D);
    check("b2b_sw_issue_ready", 32'(req_ready), 32'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("b2b_sw_resp_valid", 32'(resp_valid), 32'd1);
    check("b2b_resp_ready_low", 32'(req_ready), 32'd0);
    tick();
    check("b2b_idle_resp_valid", 32'(resp_valid), 32'd0);
    check("b2b_idle_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("b2b_lw_issue", 32'(mem_req_valid), 32'd1);
    check("b2b_lw_we", 32'(mem_we), 32'd0);
    check("b2b_lw_addr", mem_addr, 32'h8);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344;
    tick();
    mem_rvalid = 1'b0;
    check("b2b_lw_resp_valid", 32'(resp_valid), 32'd1);
    check("b2b_lw_rdata", resp_rdata, 32'h1122_3344);
    tick();

    // Reset while waiting for read data; late rvalid must be ignored
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rst_wait_no_resp", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_wait_ready_low", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
    #1;
    check("rst_wait_ready_high", 32'(req_ready), 32'd1);
    check_quiet("rst_wait");
    tick();
    mem_rvalid = 1'b0;
    check_quiet("rst_wait_late_rvalid");
    check("rst_wait_late_ready", 32'(req_ready), 32'd1);

    // Reset while a store is stalled in ISSUE
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1; req_wdata = 32'h77;
    tick();
    req_valid = 1'b0;
    check("rst_issue_valid", 32'(mem_req_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_quiet("rst_issue");
    tick();
    check("rst_issue_no_resp", 32'(resp_valid), 32'd0);

    // Randomized requests
    for (int k = 0; k < 40; k++) begin
      bit          wr   = 1'($urandom_range(0, 1));
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      do_txn($sformatf("rand%0d", k), wr, f3, addr, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
